reg_read_hazard_ctrl: RTL
=========================

# reg_read_hazard_ctrl

- Sequencing controller for the register-read (RR) stage of the 16-bit, 8-register pipeline.
- Tracks destination registers of instructions in EX, MEM and WB in a 3-deep tracking pipe.
- Generates the load-use stall and the two operand-forwarding selects.
- Drives the register file write port (`write`/`writeAdd`) from its WB entry.
- Sits beside `reg_read`: it consumes the RR stage's decoded source and destination fields and steers the operand muxes in front of EX.

## Interface
Parameters:
- `NREG`, 8: architectural register count; R7 is the PC.
- `AW`, 3: register address width.
- `CNTW`, 16: stall counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  RR stage holds a valid instruction.
- `src1_add`, `src2_add`  in  AW each  source register addresses (`readAdd1`/`readAdd2`).
- `src1_used`, `src2_used`  in  1 each  the corresponding source is actually read.
- `dst_add`  in  AW  destination register.
- `dst_wr`  in  1  instruction writes `dst_add`.
- `dst_is_load`  in  1  destination value is produced in MEM (load).
- `hold`  in  1  downstream freeze; whole tracker stalls.
- `flush`  in  1  branch mispredict; kill the RR and EX instructions.
- `stall`  out  1  RR must hold its instruction this cycle.
- `issue`  out  1  RR instruction advances into EX at this edge.
- `fwd1_sel`, `fwd2_sel`  out  2 each  operand source: RF, EX, MEM or WB.
- `wb_write`  out  1  register file write enable.
- `wb_add`  out  AW  register file write address.
- `stall_cnt`  out  CNTW  saturating count of load-use stall cycles.

## Operation
- The tracking pipe has three entries: EX, MEM, WB. Each entry is {valid, dst, is_load}. An entry is valid only if its instruction had `dst_wr`=1.
- A source matches a stage when: the source is used, the source address is not 7, the stage entry is valid, and the entry's dst equals the source address.
- R7 sources are never forwarded and never cause a stall. The register file supplies the PC value for R7.
- Load-use hazard:
  - Condition: `in_valid` and EX.valid and EX.is_load and either source matches EX.
  - Response: `stall`=1, `issue`=0, and a bubble (valid=0) enters EX.
- Forward select, evaluated per source, first match wins:
  - Matches EX and EX.is_load=0: EX (1).
  - Otherwise matches MEM: MEM (2).
  - Otherwise matches WB: WB (3).
  - Otherwise: RF (0).
  - During a load-use stall the select value is don't-care but must be stable.
- `issue` = `in_valid` & !`stall` & !`hold` & !`flush`.
- Each edge with `hold`=0:
  - WB ← MEM, MEM ← EX.
  - EX ← {`issue`&`dst_wr`, `dst_add`, `dst_is_load`}.
- `hold`=1:
  - All entries keep their values.
  - `stall`=1, `issue`=0.
  - `stall_cnt` does not count.
- `flush`=1 with `hold`=0:
  - EX becomes a bubble instead of advancing into MEM; MEM→WB still advances.
  - The RR instruction is discarded (`issue`=0).
  - `stall` is forced to 0.
  - `flush` takes priority over a load-use stall.
- `flush` and `hold` both 1: `hold` wins; the upstream stage must keep `flush` asserted until `hold` drops.
- `wb_write` = WB.valid, `wb_add` = WB.dst, both registered.
- `stall_cnt` increments by 1 on each cycle with a load-use stall and `hold`=0. It saturates at all-ones and clears only on reset.

## Timing
- `stall`, `issue` and `fwd*_sel` are combinational from the inputs and the registered tracker state, valid in the same cycle.
- Register file writeback is 3 edges after issue.
- A consumer issued the cycle after its producer forwards from EX. It forwards from MEM one cycle later and from WB the cycle after that.
- WB forwarding covers the register file's write-then-read latency.
- A load producer followed immediately by a consumer costs exactly 1 stall cycle; the consumer then forwards from MEM.
- Reset (`reset`=0 at an edge):
  - All tracker valid bits are cleared and `stall_cnt`=0.
  - The next cycle shows `wb_write`=0, `wb_add`=0, `stall`=0, and `fwd*_sel`=0.
  - Reset mid-operation discards every in-flight entry with no writeback.

## Structure
- Shared package holds:
  - `FWD_RF`=2'd0, `FWD_EX`=2'd1, `FWD_MEM`=2'd2, `FWD_WB`=2'd3.
  - `PC_REG`=3'd7.
  - The tracker entry struct {valid, dst, is_load}.
- One sub-module, `hazard_stage`: a single tracker entry register with hold, kill and load inputs, instantiated three times.
- Match, priority and stall logic live in the top module.
- The top module contains no datapath muxes; `fwd*_sel` drives the operand muxes outside it.

## Test plan
- Issue ALU write to R3, then an instruction reading R3 as src1 on the next cycle:
  - `fwd1_sel`=1, then 2, then 3 over successive consumers.
  - `wb_write`=1 with `wb_add`=3 three edges after the first issue.
- Load to R2 followed by a consumer with `src2_add`=2:
  - `stall`=1 for exactly 1 cycle with a bubble in EX.
  - Then `fwd2_sel`=2 and `stall_cnt`=1.
- Producer writes R7 and the consumer reads R7: `fwd*_sel`=0 and `stall`=0 throughout.
- Load to R1 in EX with a consumer of R1 in RR and `flush`=1:
  - `stall`=0, `issue`=0, EX becomes a bubble.
  - No writeback of R1 occurs.
- `hold`=1 for 3 cycles with entries in EX, MEM and WB:
  - Entries are unchanged and `wb_add` is stable.
  - `stall_cnt` is unchanged.
  - After release the entries resume shifting in order.
- Assert `reset`=0 mid-stream with all three stages valid:
  - All valid bits clear and `wb_write`=0 on the next cycle.
  - `stall_cnt`=0.

Source files
------------

// File: rtl/reg_read_hazard_ctrl_pkg.sv
// Shared definitions for the register-read hazard controller.
// Holds the forward-select encodings, the PC register number and the
// tracker entry layout that is used by every tracking stage.
package reg_read_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [2:0] PC_REG = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       is_load;
  } trk_entry_t;

endpackage

// File: rtl/reg_read_hazard_ctrl_if.sv
// RR-stage / hazard controller bundle.
// master: the RR stage side (drives decoded fields, hold and flush).
// slave : the hazard controller (drives stall/issue, forward selects,
//         register-file write port and the stall counter).
interface reg_read_hazard_ctrl_if #(
  parameter int AW   = 3,
  parameter int CNTW = 16
);
  logic            in_valid;
  logic [AW-1:0]   src1_add;
  logic [AW-1:0]   src2_add;
  logic            src1_used;
  logic            src2_used;
  logic [AW-1:0]   dst_add;
  logic            dst_wr;
  logic            dst_is_load;
  logic            hold;
  logic            flush;
  logic            stall;
  logic            issue;
  logic [1:0]      fwd1_sel;
  logic [1:0]      fwd2_sel;
  logic            wb_write;
  logic [AW-1:0]   wb_add;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output in_valid, src1_add, src2_add, src1_used, src2_used,
           dst_add, dst_wr, dst_is_load, hold, flush,
    input  stall, issue, fwd1_sel, fwd2_sel, wb_write, wb_add, stall_cnt
  );

  modport slave (
    input  in_valid, src1_add, src2_add, src1_used, src2_used,
           dst_add, dst_wr, dst_is_load, hold, flush,
    output stall, issue, fwd1_sel, fwd2_sel, wb_write, wb_add, stall_cnt
  );
endinterface

// File: rtl/reg_read_hazard_ctrl_hazard_stage.sv
// One tracker entry register.
// Ports: clk, reset (sync, active-low), hold (keep current entry),
// kill (load a cleared bubble instead of load_val), load_val (next entry),
// entry (registered entry).
module hazard_stage
  import reg_read_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       kill,
  input  trk_entry_t load_val,
  output trk_entry_t entry
);

  // hold outranks kill so a flush held across a freeze is applied once
  // the freeze releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry <= '0;
    end else if (hold) begin
      entry <= entry;
    end else if (kill) begin
      entry <= '0;
    end else begin
      entry <= load_val;
    end
  end

endmodule

// File: rtl/reg_read_hazard_ctrl.sv
// Register-read stage hazard controller.
// Tracks destination registers of the EX/MEM/WB instructions, raises the
// load-use stall, produces the two operand forward selects and drives the
// register-file write port from the WB entry.
// Ports: clk, reset (sync, active-low), bus (slave side of the RR bundle).
module reg_read_hazard_ctrl
  import reg_read_hazard_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_read_hazard_ctrl_if.slave bus
);

  // Highest register is the PC; the register file supplies it directly.
  localparam logic [AW-1:0] PC_ADD = AW'(NREG - 1);

  trk_entry_t      ex_q, mem_q, wb_q, ex_d;
  logic            s1_ex, s1_mem, s1_wb;
  logic            s2_ex, s2_mem, s2_wb;
  logic            load_use;
  logic            stall_int;
  logic            issue_int;
  logic [CNTW-1:0] cnt_q;

  function automatic logic src_hit(input logic used, input logic [AW-1:0] add,
                                   input trk_entry_t e);
    return used && (add != PC_ADD) && e.valid && (e.dst == add);
  endfunction

  // A load in EX has no value yet, so an EX match on a load falls through.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic ex_load,
                                          input logic hit_mem, input logic hit_wb);
    if (hit_ex && !ex_load) return FWD_EX;
    else if (hit_mem)       return FWD_MEM;
    else if (hit_wb)        return FWD_WB;
    else                    return FWD_RF;
  endfunction

  always_comb begin
    s1_ex  = src_hit(bus.src1_used, bus.src1_add, ex_q);
    s1_mem = src_hit(bus.src1_used, bus.src1_add, mem_q);
    s1_wb  = src_hit(bus.src1_used, bus.src1_add, wb_q);
    s2_ex  = src_hit(bus.src2_used, bus.src2_add, ex_q);
    s2_mem = src_hit(bus.src2_used, bus.src2_add, mem_q);
    s2_wb  = src_hit(bus.src2_used, bus.src2_add, wb_q);

    load_use  = bus.in_valid && ex_q.is_load && (s1_ex || s2_ex);
    // hold freezes everything; flush discards RR so a load-use is moot.
    stall_int = bus.hold || (load_use && !bus.flush);
    issue_int = bus.in_valid && !stall_int && !bus.flush;

    ex_d.valid   = issue_int && bus.dst_wr;
    ex_d.dst     = bus.dst_add;
    ex_d.is_load = bus.dst_is_load;

    bus.stall     = stall_int;
    bus.issue     = issue_int;
    bus.fwd1_sel  = fwd_pick(s1_ex, ex_q.is_load, s1_mem, s1_wb);
    bus.fwd2_sel  = fwd_pick(s2_ex, ex_q.is_load, s2_mem, s2_wb);
    bus.wb_write  = wb_q.valid;
    bus.wb_add    = wb_q.dst;
    bus.stall_cnt = cnt_q;
  end

  hazard_stage u_ex (
    .clk(clk), .reset(reset), .hold(bus.hold), .kill(1'b0),
    .load_val(ex_d), .entry(ex_q)
  );

  // A flush kills the instruction currently in EX on its way to MEM.
  hazard_stage u_mem (
    .clk(clk), .reset(reset), .hold(bus.hold), .kill(bus.flush),
    .load_val(ex_q), .entry(mem_q)
  );

  hazard_stage u_wb (
    .clk(clk), .reset(reset), .hold(bus.hold), .kill(1'b0),
    .load_val(mem_q), .entry(wb_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_use && !bus.flush && !bus.hold && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
